// File: rtl/chip8_mem_arbiter_if.sv
// Requester and RAM-side bundle for the CHIP-8 memory arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters' and RAM model's view.
interface chip8_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              ld_req, cpu_req, dsp_req;
    logic              ld_we, cpu_we;
    logic [ADDR_W-1:0] ld_addr, cpu_addr, dsp_addr;
    logic [DATA_W-1:0] ld_wdata, cpu_wdata;
    logic              ld_gnt, cpu_gnt, dsp_gnt;
    logic              ld_rvalid, cpu_rvalid, dsp_rvalid;
    logic [DATA_W-1:0] rd_data;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ld_req, cpu_req, dsp_req, ld_we, cpu_we,
        input  ld_addr, cpu_addr, dsp_addr, ld_wdata, cpu_wdata, mem_rdata,
        output ld_gnt, cpu_gnt, dsp_gnt, ld_rvalid, cpu_rvalid, dsp_rvalid,
        output rd_data, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_req, cpu_req, dsp_req, ld_we, cpu_we,
        output ld_addr, cpu_addr, dsp_addr, ld_wdata, cpu_wdata, mem_rdata,
        input  ld_gnt, cpu_gnt, dsp_gnt, ld_rvalid, cpu_rvalid, dsp_rvalid,
        input  rd_data, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Single-port RAM arbiter. The loader has absolute priority, and the CPU and display are served round-robin.
// The command is registered onto mem_*. The read owner is tracked so rvalid pulses one cycle after the RAM access.
module chip8_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    chip8_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DSP  = 2'd3
    } owner_e;

    logic              ld_gnt_q, ld_gnt_d, cpu_gnt_q, cpu_gnt_d, dsp_gnt_q, dsp_gnt_d;
    logic              ld_rvalid_q, ld_rvalid_d, cpu_rvalid_q, cpu_rvalid_d;
    logic              dsp_rvalid_q, dsp_rvalid_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    owner_e            owner_q, owner_d;
    logic              rr_q, rr_d;
    logic              ld_ok, cpu_ok, dsp_ok;

    // A requester granted this cycle still holds req high, so it sits out one round.
    assign ld_ok  = bus.ld_req  & ~ld_gnt_q;
    assign cpu_ok = bus.cpu_req & ~cpu_gnt_q;
    assign dsp_ok = bus.dsp_req & ~dsp_gnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        ld_gnt_d    = 1'b0;
        cpu_gnt_d   = 1'b0;
        dsp_gnt_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = OWN_NONE;
        rr_d        = rr_q;

        if (ld_ok) begin
            ld_gnt_d    = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.ld_we;
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_wdata;
            owner_d     = bus.ld_we ? OWN_NONE : OWN_LD;
        end else if (cpu_ok && (!dsp_ok || !rr_q)) begin
            cpu_gnt_d   = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            owner_d     = bus.cpu_we ? OWN_NONE : OWN_CPU;
            rr_d        = 1'b1;
        end else if (dsp_ok) begin
            dsp_gnt_d   = 1'b1;
            mem_en_d    = 1'b1;
            mem_addr_d  = bus.dsp_addr;
            owner_d     = OWN_DSP;
            rr_d        = 1'b0;
        end

        ld_rvalid_d  = (owner_q == OWN_LD);
        cpu_rvalid_d = (owner_q == OWN_CPU);
        dsp_rvalid_d = (owner_q == OWN_DSP);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated only with non-blocking assignments. The synchronous reset also flushes the owner pipeline, so a read issued before reset never produces an rvalid.
        if (rst) begin
            ld_gnt_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dsp_gnt_q    <= 1'b0;
            ld_rvalid_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dsp_rvalid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            owner_q      <= OWN_NONE;
            rr_q         <= 1'b0;
        end else begin
            ld_gnt_q     <= ld_gnt_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dsp_gnt_q    <= dsp_gnt_d;
            ld_rvalid_q  <= ld_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dsp_rvalid_q <= dsp_rvalid_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
        end
    end

    assign bus.ld_gnt     = ld_gnt_q;
    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dsp_gnt    = dsp_gnt_q;
    assign bus.ld_rvalid  = ld_rvalid_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dsp_rvalid = dsp_rvalid_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rd_data    = bus.mem_rdata;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter. It runs directed scenarios and then a randomized run against a cycle-level model of the arbitration rules.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge before new inputs are driven.
module tb_chip8_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with a backdoor preload port that is used only while the arbiter is idle.
    logic [7:0]  ram [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Control snapshot, bit order: ld_gnt cpu_gnt dsp_gnt ld_rv cpu_rv dsp_rv mem_en mem_we
    logic [7:0] ctl;
    assign ctl = {bus.ld_gnt, bus.cpu_gnt, bus.dsp_gnt, bus.ld_rvalid,
                  bus.cpu_rvalid, bus.dsp_rvalid, bus.mem_en, bus.mem_we};

    logic [7:0] shadow [4096];

    task automatic idle_all();
        bus.ld_req = 1'b0; bus.cpu_req = 1'b0; bus.dsp_req = 1'b0;
        bus.ld_we = 1'b0;  bus.cpu_we = 1'b0;
        bus.ld_addr = '0;  bus.cpu_addr = '0; bus.dsp_addr = '0;
        bus.ld_wdata = '0; bus.cpu_wdata = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ld_req = 1'b1;  bus.ld_we = 1'b0;  bus.ld_addr = 12'h001;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h002;
        bus.dsp_req = 1'b1; bus.dsp_addr = 12'h003;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (ctl !== 8'b0) begin n_errors++; $display("FAIL reset.ctl[%0d] got=%b exp=00000000", i, ctl); end
            n_checks++;
            if (bus.mem_addr !== 12'h000) begin n_errors++; $display("FAIL reset.addr[%0d] got=%h exp=000", i, bus.mem_addr); end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b1000_0010) begin n_errors++; $display("FAIL reset.first_ld ctl got=%b exp=10000010", ctl); end
        n_checks++;
        if (bus.mem_addr !== 12'h001) begin n_errors++; $display("FAIL reset.first_ld addr got=%h exp=001", bus.mem_addr); end
        bus.ld_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0101_0010) begin n_errors++; $display("FAIL reset.then_cpu ctl got=%b exp=01010010", ctl); end
        idle_all();
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0000_1000) begin n_errors++; $display("FAIL reset.cpu_rv ctl got=%b exp=00001000", ctl); end
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        do_reset();
        preload(12'h200, 8'hA2);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0100_0010) begin n_errors++; $display("FAIL cpu_read.gnt ctl got=%b exp=01000010", ctl); end
        n_checks++;
        if (bus.mem_addr !== 12'h200) begin n_errors++; $display("FAIL cpu_read.addr got=%h exp=200", bus.mem_addr); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0000_1000) begin n_errors++; $display("FAIL cpu_read.rvalid ctl got=%b exp=00001000", ctl); end
        n_checks++;
        if (bus.rd_data !== 8'hA2) begin n_errors++; $display("FAIL cpu_read.data got=%h exp=a2", bus.rd_data); end
    endtask

    task automatic test_contention();
        logic [7:0] exp;
        do_reset();
        preload(12'h300, 8'h3C);
        preload(12'hF00, 8'hF0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h300;
        bus.dsp_req = 1'b1; bus.dsp_addr = 12'hF00;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            exp = (i % 2 == 1) ? 8'b0100_0010 : 8'b0010_0010;
            if (i >= 2) exp = exp | ((i % 2 == 1) ? 8'b0000_0100 : 8'b0000_1000);
            n_checks++;
            if (ctl !== exp) begin n_errors++; $display("FAIL contention.ctl[%0d] got=%b exp=%b", i, ctl, exp); end
            n_checks++;
            if (bus.mem_addr !== ((i % 2 == 1) ? 12'h300 : 12'hF00)) begin
                n_errors++; $display("FAIL contention.addr[%0d] got=%h", i, bus.mem_addr);
            end
            if (i >= 2) begin
                n_checks++;
                if (bus.rd_data !== ((i % 2 == 1) ? 8'hF0 : 8'h3C)) begin
                    n_errors++; $display("FAIL contention.data[%0d] got=%h", i, bus.rd_data);
                end
            end
        end
        idle_all();
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0000_0100) begin n_errors++; $display("FAIL contention.tail ctl got=%b exp=00000100", ctl); end
        n_checks++;
        if (bus.rd_data !== 8'hF0) begin n_errors++; $display("FAIL contention.tail data got=%h exp=f0", bus.rd_data); end
    endtask

    task automatic test_loader_preempt();
        do_reset();
        preload(12'h010, 8'h11);
        bus.ld_req = 1'b1;  bus.ld_we = 1'b1;  bus.ld_addr = 12'h000; bus.ld_wdata = 8'h55;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h010;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b1000_0011) begin n_errors++; $display("FAIL loader.gnt ctl got=%b exp=10000011", ctl); end
        n_checks++;
        if (bus.mem_wdata !== 8'h55 || bus.mem_addr !== 12'h000) begin
            n_errors++; $display("FAIL loader.cmd got=%h@%h exp=55@000", bus.mem_wdata, bus.mem_addr);
        end
        bus.ld_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0100_0010) begin n_errors++; $display("FAIL loader.cpu_gap ctl got=%b exp=01000010", ctl); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0000_1000 || bus.rd_data !== 8'h11) begin
            n_errors++; $display("FAIL loader.cpu_rv ctl=%b data=%h exp=00001000/11", ctl, bus.rd_data);
        end
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h000;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0000_1000 || bus.rd_data !== 8'h55) begin
            n_errors++; $display("FAIL loader.readback ctl=%b data=%h exp=00001000/55", ctl, bus.rd_data);
        end
    endtask

    task automatic test_dsp_mask();
        logic [7:0] exp;
        do_reset();
        bus.dsp_req = 1'b1; bus.dsp_addr = 12'h0F0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) idle_all();
            @(negedge clk);
            exp = (i % 2 == 1 && i <= 5) ? 8'b0010_0010 : 8'b0000_0100;
            n_checks++;
            if (ctl !== exp) begin n_errors++; $display("FAIL dsp_mask.ctl[%0d] got=%b exp=%b", i, ctl, exp); end
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        preload(12'h123, 8'h77);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h123;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0100_0010) begin n_errors++; $display("FAIL mid_reset.gnt ctl got=%b exp=01000010", ctl); end
        bus.cpu_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 8'b0 || bus.mem_addr !== 12'h000 || bus.mem_wdata !== 8'h00) begin
            n_errors++; $display("FAIL mid_reset.clear ctl=%b addr=%h wdata=%h exp=0", ctl, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
    endtask

    // Randomized requesters with a cycle-level model: index 0 = loader, 1 = CPU, 2 = display.
    task automatic test_random();
        localparam int N = 3000;
        logic        r_req [3];
        logic        r_we [3];
        logic [11:0] r_addr [3];
        logic [7:0]  r_wdata [3];
        logic [2:0]  m_gnt, n_gnt, m_rv, n_rv, obs;
        logic        m_rr, m_en, m_we;
        logic [11:0] m_addr, a;
        logic [7:0]  m_wdata, m_rd, n_rd, d;
        int          m_owner, w;
        bit          raise_ok;

        do_reset();
        for (int k = 0; k < 16; k++) begin
            a = 12'hFF8 + 12'(k);
            d = 8'($urandom);
            shadow[a] = d;
            preload(a, d);
        end
        m_gnt = '0; m_rv = '0; m_rr = 1'b0; m_en = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_rd = '0; m_owner = 0;
        for (int i = 0; i < 3; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end

        for (int cyc = 0; cyc < N; cyc++) begin
            obs = {bus.dsp_gnt, bus.cpu_gnt, bus.ld_gnt};
            n_checks++;
            if (obs !== m_gnt) begin n_errors++; $display("FAIL rand.gnt cyc=%0d got=%b exp=%b", cyc, obs, m_gnt); end
            n_checks++;
            if ({bus.mem_en, bus.mem_we} !== {m_en, m_we}) begin
                n_errors++; $display("FAIL rand.en_we cyc=%0d got=%b%b exp=%b%b", cyc, bus.mem_en, bus.mem_we, m_en, m_we);
            end
            n_checks++;
            if (bus.mem_addr !== m_addr) begin n_errors++; $display("FAIL rand.addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, m_addr); end
            if (m_en && m_we) begin
                n_checks++;
                if (bus.mem_wdata !== m_wdata) begin n_errors++; $display("FAIL rand.wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_wdata, m_wdata); end
            end
            obs = {bus.dsp_rvalid, bus.cpu_rvalid, bus.ld_rvalid};
            n_checks++;
            if (obs !== m_rv) begin n_errors++; $display("FAIL rand.rvalid cyc=%0d got=%b exp=%b", cyc, obs, m_rv); end
            if (m_rv != 3'b0) begin
                n_checks++;
                if (bus.rd_data !== m_rd) begin n_errors++; $display("FAIL rand.data cyc=%0d got=%h exp=%h", cyc, bus.rd_data, m_rd); end
            end

            // Requesters: a request is held until granted, then it may drop or be replaced by a new one.
            raise_ok = (cyc < N - 10);
            for (int r = 0; r < 3; r++) begin
                if ((r_req[r] && m_gnt[r]) || !r_req[r]) begin
                    r_req[r]   = raise_ok && (r_req[r] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0));
                    r_we[r]    = (r == 2) ? 1'b0 : 1'($urandom);
                    r_addr[r]  = 12'hFF8 + 12'($urandom_range(0, 15));
                    r_wdata[r] = 8'($urandom);
                end
            end

            // The RAM access on the bus this cycle defines the next rvalid and data.
            n_rv = '0; n_rd = m_rd;
            if (m_en && !m_we) begin n_rv[m_owner] = 1'b1; n_rd = shadow[m_addr]; end
            if (m_en && m_we) shadow[m_addr] = m_wdata;

            // Arbitration: a requester granted this cycle is ineligible.
            w = -1;
            if (r_req[0] && !m_gnt[0]) w = 0;
            else if (r_req[1] && !m_gnt[1] && r_req[2] && !m_gnt[2]) w = m_rr ? 2 : 1;
            else if (r_req[1] && !m_gnt[1]) w = 1;
            else if (r_req[2] && !m_gnt[2]) w = 2;

            n_gnt = '0;
            m_en = (w >= 0);
            m_we = 1'b0;
            if (w >= 0) begin
                n_gnt[w] = 1'b1;
                m_we     = r_we[w];
                m_addr   = r_addr[w];
                if (w != 2) m_wdata = r_wdata[w];
                m_owner  = w;
                if (w == 1) m_rr = 1'b1;
                if (w == 2) m_rr = 1'b0;
            end
            m_gnt = n_gnt; m_rv = n_rv; m_rd = n_rd;

            bus.ld_req = r_req[0];  bus.ld_we = r_we[0];   bus.ld_addr = r_addr[0];  bus.ld_wdata = r_wdata[0];
            bus.cpu_req = r_req[1]; bus.cpu_we = r_we[1];  bus.cpu_addr = r_addr[1]; bus.cpu_wdata = r_wdata[1];
            bus.dsp_req = r_req[2]; bus.dsp_addr = r_addr[2];
            @(negedge clk);
        end
        idle_all();
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_contention();
        test_loader_preempt();
        test_dsp_mask();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
